// File: rtl/dual_port_ram_if.sv
// Signal bundle for the dual_port_ram scratch store.
// The bench drives the master side; the RAM's flat ports correspond to the slave side.
interface dual_port_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_enb;
    logic                  rd_enb;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output din, output addr, output wr_enb, output rd_enb, input dout);
    modport slave  (input din, input addr, input wr_enb, input rd_enb, output dout);
endinterface

// File: rtl/dual_port_ram.sv
// 16x8 single-clock RAM with a shared address bus and one-cycle registered read.
// A same-cycle write and read at that address returns the new data.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  clock,
    input  logic                  wr_enb,
    input  logic                  rd_enb,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  wr_active;
    logic                  rd_active;

    assign wr_active = (wr_enb == 1'b1);
    assign rd_active = (rd_enb == 1'b1);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_active) begin
            mem_d[addr] = din;
        end
    end

    // Write process: reset clears every word so the store always starts clean.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Bypass mux: on a same-cycle write, the array still holds the old word.
    always_comb begin
        read_data = mem_q[addr];
        if (wr_active) begin
            read_data = din;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (rd_active) begin
            dout_d = read_data;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed vector table, reset corner cases,
// and a randomized run scored against a simple array model of the store.
module tb_dual_port_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clock;
    logic rst;

    dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .din    (bus.din),
        .addr   (bus.addr),
        .clock  (clock),
        .wr_enb (bus.wr_enb),
        .rd_enb (bus.rd_enb),
        .rst    (rst),
        .dout   (bus.dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_dout;
        string         name;
    } vector_t;

    vector_t vectors[$];

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;

    task automatic check_dout(input string name, input logic [DW-1:0] expected);
        total++;
        if (bus.dout === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: dout=%h expected=%h at %0t", name, bus.dout, expected, $time);
        end
    endtask

    // One clocked operation: drive on the falling edge, sample 1ns after the rising edge.
    task automatic apply_op(input logic wr, input logic rd, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        @(negedge clock);
        bus.wr_enb = wr;
        bus.rd_enb = rd;
        bus.addr   = a;
        bus.din    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic model_op(input logic wr, input logic rd, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        if (rd) ref_dout = wr ? d : ref_mem[a];
        if (wr) ref_mem[a] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_dout = '0;
    endtask

    // Asserts reset partway through a clock-high phase, checks dout clears at once.
    task automatic mid_cycle_reset(input string name);
        #2;
        rst = 1'b0;
        #1;
        check_dout(name, 8'h00);
        @(negedge clock);
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.din    = '0;
        bus.addr   = '0;
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        rst        = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_dout("reset_initial", 8'h00);

        // Enables asserted during reset must be ignored.
        bus.wr_enb = 1'b1;
        bus.rd_enb = 1'b1;
        bus.addr   = 4'd1;
        bus.din    = 8'h77;
        repeat (2) @(posedge clock);
        #1;
        check_dout("reset_held_ignores_ops", 8'h00);
        @(negedge clock);
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        rst = 1'b1;
        model_reset();

        apply_op(1'b0, 1'b1, 4'd1, 8'h00);
        check_dout("no_write_during_reset", 8'h00);

        // Preload, then async reset mid-cycle, then read back the cleared word.
        apply_op(1'b1, 1'b0, 4'd3, 8'hA5);
        apply_op(1'b0, 1'b1, 4'd3, 8'h00);
        check_dout("preload_read", 8'hA5);
        mid_cycle_reset("reset_async_clear");
        apply_op(1'b0, 1'b1, 4'd3, 8'h00);
        check_dout("read_after_reset", 8'h00);

        for (int i = 0; i < DEPTH; i++)
            vectors.push_back('{1'b1, 1'b0, AW'(i), DW'(i * 3), 8'h00, "write_sweep"});
        for (int i = 0; i < DEPTH; i++)
            vectors.push_back('{1'b0, 1'b1, AW'(i), 8'h00, DW'(i * 3), "read_sweep"});
        vectors.push_back('{1'b0, 1'b1, 4'd5, 8'h00, 8'd15, "read_addr5"});
        vectors.push_back('{1'b0, 1'b0, 4'd9, 8'h00, 8'd15, "read_hold"});
        vectors.push_back('{1'b0, 1'b0, 4'd9, 8'hEE, 8'd15, "read_hold2"});
        vectors.push_back('{1'b1, 1'b1, 4'd7, 8'h3C, 8'h3C, "write_through"});
        vectors.push_back('{1'b0, 1'b1, 4'd0, 8'h00, 8'h00, "read_addr0"});
        vectors.push_back('{1'b0, 1'b1, 4'd7, 8'h00, 8'h3C, "reread_addr7"});
        vectors.push_back('{1'b0, 1'b0, 4'd2, 8'hFF, 8'h3C, "wr_disabled1"});
        vectors.push_back('{1'b0, 1'b0, 4'd2, 8'hFF, 8'h3C, "wr_disabled2"});
        vectors.push_back('{1'b0, 1'b0, 4'd2, 8'hFF, 8'h3C, "wr_disabled3"});
        vectors.push_back('{1'b0, 1'b1, 4'd2, 8'h00, 8'd6,  "read_addr2"});
        vectors.push_back('{1'b0, 1'b1, 4'd15, 8'h00, 8'd45, "read_addr15"});

        foreach (vectors[k]) begin
            apply_op(vectors[k].wr, vectors[k].rd, vectors[k].addr, vectors[k].din);
            model_op(vectors[k].wr, vectors[k].rd, vectors[k].addr, vectors[k].din);
            check_dout(vectors[k].name, vectors[k].exp_dout);
        end

        // Randomized mix scored against the array model.
        for (int n = 0; n < 300; n++) begin
            logic          wr;
            logic          rd;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            wr = ($urandom_range(0, 99) < 50);
            rd = ($urandom_range(0, 99) < 60);
            a  = AW'($urandom_range(0, DEPTH - 1));
            d  = DW'($urandom_range(0, 49));
            apply_op(wr, rd, a, d);
            model_op(wr, rd, a, d);
            check_dout("random_op", ref_dout);
        end

        // A write in flight when reset hits must not survive.
        @(negedge clock);
        bus.wr_enb = 1'b1;
        bus.rd_enb = 1'b0;
        bus.addr   = 4'd4;
        bus.din    = 8'h2A;
        @(posedge clock);
        mid_cycle_reset("reset_after_random");
        for (int i = 0; i < DEPTH; i++) begin
            apply_op(1'b0, 1'b1, AW'(i), 8'h00);
            check_dout("cleared_sweep", 8'h00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
